uart_rx_deserializer: RTL and testbench

//   UART receiver stage, directly downstream of the RX-line debouncer. Takes the debounced,
//   CLK-synchronous serial line and recovers 8N1/8E1/8O1 frames by mid-bit sampling.

---
 rtl/uart_rx_deserializer.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// Recovers 8N1 / 8E1 / 8O1 frames from the debounced, CLK-synchronous RX line.
// Each bit is sampled in its middle: the start bit is confirmed HALF cycles
// after the falling edge, and every later bit is sampled CLK_DIV cycles after
// the previous sample. The received byte is presented with a one-cycle
// strobe, together with frame and parity error flags that hold until the
// next strobe.

module uart_rx_deserializer #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0          // 0 = none, 1 = even, 2 = odd
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DOUT,
  output logic       DOUT_VLD,
  output logic       FRAME_ERROR,
  output logic       PARITY_ERROR,
  output logic       RX_BUSY
);

  // Bit timing derived from the clock and the baud rate.
  localparam int CLK_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W   = $clog2(CLK_DIV);
  localparam int HALF    = CLK_DIV / 2;

  // Terminal counts for the start-bit check and for one full bit period.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(CLK_DIV - 1);

  // Parity mode as a 2-bit code for the checker function.
  localparam logic [1:0] PAR_MODE = 2'(PARITY);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] clk_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shreg_r;
  logic             par_err_r;
  logic [7:0]       dout_r;
  logic             dout_vld_r;
  logic             frame_err_r;
  logic             parity_err_r;
  logic             busy_r;

  // Parity check of the received byte against the received parity bit.
  // Even mode: the nine bits must contain an even number of ones.
  // Odd mode: the nine bits must contain an odd number of ones.
  // With parity disabled no error can ever be reported.
  function automatic logic parity_err(input logic [7:0] data,
                                      input logic       pbit,
                                      input logic [1:0] mode);
    logic err_s;
    case (mode)
      2'd1:    err_s = ^{data, pbit};
      2'd2:    err_s = ~^{data, pbit};
      default: err_s = 1'b0;
    endcase
    return err_s;
  endfunction

  // Receive FSM: bit timing, shifting, error capture and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      clk_cnt_r    <= '0;
      bit_cnt_r    <= 3'd0;
      shreg_r      <= 8'h00;
      par_err_r    <= 1'b0;
      dout_r       <= 8'h00;
      dout_vld_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      // The strobe is a single-cycle pulse unless the stop bit is taken below.
      dout_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A low line is a candidate start edge; it is confirmed at mid-bit.
          if (!RXD) begin
            state_r   <= ST_START;
            clk_cnt_r <= '0;
            busy_r    <= 1'b1;
          end else begin
            clk_cnt_r <= '0;
            busy_r    <= 1'b0;
          end
        end

        ST_START: begin
          if (clk_cnt_r == HALF_M1) begin
            clk_cnt_r <= '0;
            if (!RXD) begin
              // Still low in the middle of the start bit: a real frame.
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              // The low was too short to be a start bit: silently drop it.
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (clk_cnt_r == DIV_M1) begin
            clk_cnt_r          <= '0;
            shreg_r[bit_cnt_r] <= RXD;
            bit_cnt_r          <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end

        ST_PARITY: begin
          if (clk_cnt_r == DIV_M1) begin
            clk_cnt_r <= '0;
            par_err_r <= parity_err(shreg_r, RXD, PAR_MODE);
            state_r   <= ST_STOP;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (clk_cnt_r == DIV_M1) begin
            // Deliver the byte even when the stop bit is bad; the flag says so.
            clk_cnt_r    <= '0;
            dout_r       <= shreg_r;
            frame_err_r  <= ~RXD;
            parity_err_r <= par_err_r;
            dout_vld_r   <= 1'b1;
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          clk_cnt_r <= '0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign DOUT         = dout_r;
  assign DOUT_VLD     = dout_vld_r;
  assign FRAME_ERROR  = frame_err_r;
  assign PARITY_ERROR = parity_err_r;
  assign RX_BUSY      = busy_r;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
// Three receivers (no parity, even, odd) share clock and reset, each with its
// own RX line. Expected bytes are queued as frames are driven; a monitor
// records every strobe, and each test task compares the two queues.

module tb_uart_rx_deserializer;

  logic       CLK;
  logic       RST;
  logic [2:0] rxd;
  logic [7:0] dout [3];
  logic       vld  [3];
  logic       fe   [3];
  logic       pe   [3];
  logic       busy [3];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int start_cyc   = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         cyc;
  } rec_t;

  rec_t exp_q0[$], exp_q1[$], exp_q2[$];
  rec_t obs_q0[$], obs_q1[$], obs_q2[$];

  uart_rx_deserializer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(0)) u_none (
    .CLK(CLK), .RST(RST), .RXD(rxd[0]), .DOUT(dout[0]), .DOUT_VLD(vld[0]),
    .FRAME_ERROR(fe[0]), .PARITY_ERROR(pe[0]), .RX_BUSY(busy[0]));

  uart_rx_deserializer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(1)) u_even (
    .CLK(CLK), .RST(RST), .RXD(rxd[1]), .DOUT(dout[1]), .DOUT_VLD(vld[1]),
    .FRAME_ERROR(fe[1]), .PARITY_ERROR(pe[1]), .RX_BUSY(busy[1]));

  uart_rx_deserializer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(2)) u_odd (
    .CLK(CLK), .RST(RST), .RXD(rxd[2]), .DOUT(dout[2]), .DOUT_VLD(vld[2]),
    .FRAME_ERROR(fe[2]), .PARITY_ERROR(pe[2]), .RX_BUSY(busy[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every strobe cycle of every receiver, away from the active edge.
  always @(negedge CLK) begin
    rec_t r;
    if (vld[0] === 1'b1) begin
      r.d = dout[0]; r.fe = fe[0]; r.pe = pe[0]; r.cyc = cyc; obs_q0.push_back(r);
    end
    if (vld[1] === 1'b1) begin
      r.d = dout[1]; r.fe = fe[1]; r.pe = pe[1]; r.cyc = cyc; obs_q1.push_back(r);
    end
    if (vld[2] === 1'b1) begin
      r.d = dout[2]; r.fe = fe[2]; r.pe = pe[2]; r.cyc = cyc; obs_q2.push_back(r);
    end
  end

  // Hold one RX line at a level for n clock cycles; returns 1 time unit after an edge.
  task automatic set_line(input int inst, input logic v, input int n);
    rxd[inst] = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive one frame and queue what the receiver should report for it.
  task automatic send_frame(input int inst, input logic [7:0] d,
                            input logic pbit, input logic stop);
    rec_t e;
    int   ones;
    ones  = $countones(d) + int'(pbit);
    e.d   = d;
    e.fe  = ~stop;
    e.cyc = 0;
    case (inst)
      1:       e.pe = (ones % 2) == 1;
      2:       e.pe = (ones % 2) == 0;
      default: e.pe = 1'b0;
    endcase
    case (inst)
      1:       exp_q1.push_back(e);
      2:       exp_q2.push_back(e);
      default: exp_q0.push_back(e);
    endcase
    start_cyc = cyc;
    set_line(inst, 1'b0, 16);
    for (int i = 0; i < 8; i++) set_line(inst, d[i], 16);
    if (inst != 0) set_line(inst, pbit, 16);
    set_line(inst, stop, 16);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    rxd = 3'b111;
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({dout[i], vld[i], fe[i], pe[i], busy[i]} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got dout=%h vld=%b fe=%b pe=%b busy=%b, expected all 0",
                 i, dout[i], vld[i], fe[i], pe[i], busy[i]);
      end
    end
    RST = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    rec_t o, e;
    send_frame(0, 8'h55, 1'b0, 1'b1);
    set_line(0, 1'b1, 16);
    vectors++;
    if (obs_q0.size() != 1) begin
      miscompares++;
      $display("FAIL basic_strobes: got %0d strobe cycles, expected 1", obs_q0.size());
    end
    while (obs_q0.size() > 0 && exp_q0.size() > 0) begin
      o = obs_q0.pop_front();
      e = exp_q0.pop_front();
      vectors++;
      if ({o.d, o.fe, o.pe} !== {e.d, e.fe, e.pe}) begin
        miscompares++;
        $display("FAIL basic_data: got %h fe=%b pe=%b, expected %h fe=%b pe=%b",
                 o.d, o.fe, o.pe, e.d, e.fe, e.pe);
      end
      vectors++;
      if (o.cyc - start_cyc != 153) begin
        miscompares++;
        $display("FAIL basic_latency: got %0d cycles, expected 153", o.cyc - start_cyc);
      end
    end
    exp_q0.delete();
    obs_q0.delete();
  endtask

  task automatic test_parity();
    rec_t o, e;
    send_frame(1, 8'hA3, 1'b0, 1'b1); set_line(1, 1'b1, 16);
    send_frame(1, 8'hA3, 1'b1, 1'b1); set_line(1, 1'b1, 16);
    send_frame(2, 8'hA3, 1'b1, 1'b1); set_line(2, 1'b1, 16);
    send_frame(2, 8'hA3, 1'b0, 1'b1); set_line(2, 1'b1, 16);
    vectors++;
    if (obs_q1.size() != 2 || obs_q2.size() != 2) begin
      miscompares++;
      $display("FAIL parity_strobes: got %0d/%0d, expected 2/2", obs_q1.size(), obs_q2.size());
    end
    while (obs_q1.size() > 0 && exp_q1.size() > 0) begin
      o = obs_q1.pop_front();
      e = exp_q1.pop_front();
      vectors++;
      if ({o.d, o.fe, o.pe} !== {e.d, e.fe, e.pe}) begin
        miscompares++;
        $display("FAIL parity_even: got %h fe=%b pe=%b, expected %h fe=%b pe=%b",
                 o.d, o.fe, o.pe, e.d, e.fe, e.pe);
      end
    end
    while (obs_q2.size() > 0 && exp_q2.size() > 0) begin
      o = obs_q2.pop_front();
      e = exp_q2.pop_front();
      vectors++;
      if ({o.d, o.fe, o.pe} !== {e.d, e.fe, e.pe}) begin
        miscompares++;
        $display("FAIL parity_odd: got %h fe=%b pe=%b, expected %h fe=%b pe=%b",
                 o.d, o.fe, o.pe, e.d, e.fe, e.pe);
      end
    end
    exp_q1.delete(); obs_q1.delete();
    exp_q2.delete(); obs_q2.delete();
  endtask

  task automatic test_frame_error();
    rec_t o, e;
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    set_line(0, 1'b1, 32);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    set_line(0, 1'b1, 32);
    vectors++;
    if (obs_q0.size() != 2) begin
      miscompares++;
      $display("FAIL frame_err_strobes: got %0d, expected 2", obs_q0.size());
    end
    while (obs_q0.size() > 0 && exp_q0.size() > 0) begin
      o = obs_q0.pop_front();
      e = exp_q0.pop_front();
      vectors++;
      if ({o.d, o.fe, o.pe} !== {e.d, e.fe, e.pe}) begin
        miscompares++;
        $display("FAIL frame_err_data: got %h fe=%b pe=%b, expected %h fe=%b pe=%b",
                 o.d, o.fe, o.pe, e.d, e.fe, e.pe);
      end
    end
    vectors++;
    if (dout[0] !== 8'h81 || fe[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_after_strobe: got dout=%h fe=%b, expected 81 fe=0", dout[0], fe[0]);
    end
    exp_q0.delete();
    obs_q0.delete();
  endtask

  task automatic test_glitch();
    rec_t o, e;
    set_line(0, 1'b0, 4);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy_high: got %b, expected 1", busy[0]);
    end
    set_line(0, 1'b1, 16);
    vectors++;
    if (busy[0] !== 1'b0 || obs_q0.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_dropped: got busy=%b strobes=%0d, expected busy=0 strobes=0",
               busy[0], obs_q0.size());
    end
    send_frame(0, 8'h0F, 1'b0, 1'b1);
    set_line(0, 1'b1, 16);
    vectors++;
    if (obs_q0.size() != 1) begin
      miscompares++;
      $display("FAIL glitch_next_strobes: got %0d, expected 1", obs_q0.size());
    end
    while (obs_q0.size() > 0 && exp_q0.size() > 0) begin
      o = obs_q0.pop_front();
      e = exp_q0.pop_front();
      vectors++;
      if ({o.d, o.fe, o.pe} !== {e.d, e.fe, e.pe}) begin
        miscompares++;
        $display("FAIL glitch_next_data: got %h fe=%b pe=%b, expected %h fe=%b pe=%b",
                 o.d, o.fe, o.pe, e.d, e.fe, e.pe);
      end
    end
    exp_q0.delete();
    obs_q0.delete();
  endtask

  task automatic test_reset_mid_frame();
    rec_t o, e;
    logic [7:0] d;
    d = 8'h99;
    set_line(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) set_line(0, d[i], 16);
    set_line(0, d[3], 8);
    #1;
    RST = 1'b1;
    #1;
    vectors++;
    if ({dout[0], vld[0], fe[0], pe[0], busy[0]} !== 12'h000) begin
      miscompares++;
      $display("FAIL async_reset: got dout=%h vld=%b fe=%b pe=%b busy=%b, expected all 0",
               dout[0], vld[0], fe[0], pe[0], busy[0]);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    set_line(0, 1'b1, 40);
    vectors++;
    if (obs_q0.size() != 0) begin
      miscompares++;
      $display("FAIL reset_no_strobe: got %0d strobes, expected 0", obs_q0.size());
    end
    send_frame(0, 8'hC6, 1'b0, 1'b1);
    set_line(0, 1'b1, 16);
    vectors++;
    if (obs_q0.size() != 1) begin
      miscompares++;
      $display("FAIL reset_next_strobes: got %0d, expected 1", obs_q0.size());
    end
    while (obs_q0.size() > 0 && exp_q0.size() > 0) begin
      o = obs_q0.pop_front();
      e = exp_q0.pop_front();
      vectors++;
      if ({o.d, o.fe, o.pe} !== {e.d, e.fe, e.pe}) begin
        miscompares++;
        $display("FAIL reset_next_data: got %h fe=%b pe=%b, expected %h fe=%b pe=%b",
                 o.d, o.fe, o.pe, e.d, e.fe, e.pe);
      end
    end
    exp_q0.delete();
    obs_q0.delete();
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    set_line(0, 1'b1, 32);
    vectors++;
    if (obs_q0.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_strobes: got %0d, expected 3", obs_q0.size());
    end
    while (obs_q0.size() > 0 && exp_q0.size() > 0) begin
      o = obs_q0.pop_front();
      e = exp_q0.pop_front();
      vectors++;
      if ({o.d, o.fe, o.pe} !== {e.d, e.fe, e.pe}) begin
        miscompares++;
        $display("FAIL b2b_data: got %h fe=%b pe=%b, expected %h fe=%b pe=%b",
                 o.d, o.fe, o.pe, e.d, e.fe, e.pe);
      end
    end
    exp_q0.delete();
    obs_q0.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
